write_frame_func: RTL and testbench
===================================

# write_frame_func

Parametrised Ethernet frame writer that sits between a scheduling controller and the `eth_axis_tx` header/payload interface. On a start request it latches a 14-byte header (destination MAC, source MAC, EtherType) and a payload descriptor (base address, beat count). It presents the header with a valid/ready handshake, then streams the payload from a synchronous-read memory port as AXI-Stream beats with `tlast`. It is the successor to the header-only writer: it adds payload streaming, variable length (including zero), back-pressure handling, back-to-back frames and a frame counter.

## Interface
- `DATA_WIDTH`, default 8, payload beat width in bits (`tdata` and memory `rdata`).
- `ADDR_WIDTH`, default 16, payload memory address width.
- `LEN_WIDTH`, default 16, payload beat-count width.
- `CNT_WIDTH`, default 16, frame counter width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  frame request; accepted only when `start_ready`=1.
- `start_ready`  out  1  high in IDLE only.
- `dest_mac`  in  48  destination MAC, sampled on accepted start.
- `src_mac`  in  48  source MAC, sampled on accepted start.
- `eth_type`  in  16  EtherType, sampled on accepted start.
- `payload_base`  in  ADDR_WIDTH  first payload word address, sampled on accepted start.
- `payload_len`  in  LEN_WIDTH  number of payload beats, sampled on accepted start; 0 is legal.
- `mem_raddr`  out  ADDR_WIDTH  payload memory read address.
- `mem_rdata`  in  DATA_WIDTH  read data, equal to mem[`mem_raddr` of the previous cycle].
- `s_eth_hdr_valid`  out  1  header valid.
- `s_eth_hdr_ready`  in  1  header ready.
- `s_eth_dest_mac`  out  48  latched destination MAC.
- `s_eth_src_mac`  out  48  latched source MAC.
- `s_eth_type`  out  16  latched EtherType.
- `s_eth_payload_axis_tdata`  out  DATA_WIDTH  payload beat.
- `s_eth_payload_axis_tvalid`  out  1  payload valid.
- `s_eth_payload_axis_tready`  in  1  payload ready.
- `s_eth_payload_axis_tlast`  out  1  final beat marker.
- `s_eth_payload_axis_tuser`  out  1  tied 0.
- `m_axis_tready`  out  1  tied 0; receive path unused.
- `busy`  in  1  transmitter busy; ignored.
- `valid`  out  1  one-cycle frame-complete pulse.
- `frame_count`  out  CNT_WIDTH  completed frames; wraps modulo 2^CNT_WIDTH.

## Operation
- **States.** IDLE, HDR, FETCH, SEND, DONE.
- **IDLE.**
  - `start_ready`=1.
  - On `start`=1: latch all descriptor inputs, set `idx`=0, go to HDR.
- **HDR.**
  - `s_eth_hdr_valid`=1.
  - On `s_eth_hdr_ready`=1: go to FETCH if latched length > 0, otherwise go to DONE.
  - `s_eth_hdr_valid` never drops before the handshake.
- **FETCH.** One cycle with `mem_raddr`=base+`idx` and `tvalid`=0; then go to SEND.
- **SEND.**
  - `tvalid`=1, `tdata`=`mem_rdata`.
  - `tlast`=1 when `idx`=len−1.
  - `mem_raddr`=base+`idx`+1 when `tvalid`&`tready`, otherwise base+`idx`. This is combinational, so that next cycle's `rdata` matches the next beat.
  - On handshake, `idx` increments. On a handshake with `tlast`=1, go to DONE.
- **DONE.**
  - `valid`=1 for exactly this cycle.
  - `frame_count` increments; it is visible in the next cycle.
  - Next state is IDLE.
- **Header outputs.** `s_eth_dest_mac`, `s_eth_src_mac`, `s_eth_type` drive the latched registers. They stay stable from the accepting edge until the next accepted start, and are not cleared in IDLE.
- **`mem_raddr` in IDLE/HDR/DONE.** Equals latched base.
- **Address arithmetic.** base+`idx` is truncated to ADDR_WIDTH and wraps at 2^ADDR_WIDTH without error.
- **`idx` width.** LEN_WIDTH.
- **Maximum length.** `payload_len`=2^LEN_WIDTH−1 is supported.
- **`start` outside IDLE.** Ignored; it is not queued.
- **Reset.** Asserting `rst` in any state, including mid-payload, immediately forces IDLE. It clears all latched registers, `idx` and `frame_count` to 0. No further `tvalid` is driven; the partial frame is abandoned without `tlast`.

## Timing
- **Reset values.**
  - `start_ready`=1.
  - `s_eth_hdr_valid`, `tvalid`, `tlast`, `tuser`, `m_axis_tready`, `valid` = 0.
  - `s_eth_*` data = 0, `tdata` = 0 (`tdata` is gated to 0 outside SEND), `mem_raddr`=0, `frame_count`=0.
- **Start to header.** `start` accepted at edge E: `s_eth_hdr_valid`=1 in the cycle after E.
- **Header to first beat.** Header handshake at edge H: FETCH in cycle H+1, first `tvalid` in cycle H+2.
- **Throughput.** With `tready` held high, one beat per cycle. An N-beat payload occupies N SEND cycles.
- **Stall.** While `tvalid`=1 and `tready`=0, `tdata`, `tlast` and `mem_raddr` are held.
- **Completion.** Last-beat handshake at edge L: `valid`=1 in cycle L+1, `start_ready`=1 in cycle L+2.
- **Zero length.** Header handshake at H: `valid` in cycle H+1.
- **Back-to-back.** Minimum frame spacing is 1 IDLE cycle between DONE and the next HDR.

## Test plan
- **Basic frame.** dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800, base=0x0010, len=4, mem[0x10..0x13]=0xA1..0xA4, ready always high.
  - Header fields as given, one hdr handshake.
  - Beats 0xA1..0xA4 on 4 consecutive cycles, `tlast` only on 0xA4.
  - `valid` pulse one cycle later; `frame_count`=1.
- **Back-pressure.** Same frame with `tready` toggling 1,0,0,1,…; `hdr_ready` low for 3 cycles after `hdr_valid`.
  - `hdr_valid` and header data stable until handshake.
  - Beat data held during stalls, no beat duplicated or skipped, sequence still 0xA1..0xA4.
- **Zero length.** len=0.
  - Header handshake, then `valid` the next cycle.
  - `tvalid` never asserted; `frame_count` increments.
- **Address wrap.** ADDR_WIDTH=4, base=0xE, len=4.
  - Read addresses 0xE,0xF,0x0,0x1; data matches those locations.
- **Ignored start / back-to-back.** Pulse `start` during SEND with a different descriptor.
  - Ignored; the current frame is unchanged.
  - A second start in the first IDLE cycle after DONE produces a second frame; `frame_count`=2.
- **Reset mid-payload.** Assert `rst` after beat 2 of 4.
  - All outputs at reset values immediately; `frame_count`=0; no `tlast`.
  - A new frame after deassertion completes normally.

Source files
------------

// File: rtl/write_frame_func.sv
// Ethernet frame writer: latches a header and payload descriptor on start, hands the header
// over with valid/ready, then streams the payload from a synchronous-read memory with tlast.
module write_frame_func #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  start_ready,
  input  logic [47:0]           dest_mac,
  input  logic [47:0]           src_mac,
  input  logic [15:0]           eth_type,
  input  logic [ADDR_WIDTH-1:0] payload_base,
  input  logic [LEN_WIDTH-1:0]  payload_len,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  s_eth_hdr_valid,
  input  logic                  s_eth_hdr_ready,
  output logic [47:0]           s_eth_dest_mac,
  output logic [47:0]           s_eth_src_mac,
  output logic [15:0]           s_eth_type,
  output logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  output logic                  s_eth_payload_axis_tvalid,
  input  logic                  s_eth_payload_axis_tready,
  output logic                  s_eth_payload_axis_tlast,
  output logic                  s_eth_payload_axis_tuser,
  output logic                  m_axis_tready,
  input  logic                  busy,
  output logic                  valid,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [47:0]             dest_r;
  logic [47:0]             src_r;
  logic [15:0]             type_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    idx_r;
  logic [CNT_WIDTH-1:0]    frame_count_r;
  logic                    start_acc_s;
  logic                    beat_hs_s;
  logic                    last_beat_s;
  logic                    unused_busy_s;

  assign unused_busy_s = busy;

  assign start_acc_s  = (state_r == IDLE) && start;
  assign last_beat_s  = (state_r == SEND) && (idx_r == (len_r - LEN_WIDTH'(1'b1)));
  assign beat_hs_s    = (state_r == SEND) && s_eth_payload_axis_tready;

  assign start_ready               = (state_r == IDLE);
  assign s_eth_hdr_valid           = (state_r == HDR);
  assign s_eth_payload_axis_tvalid = (state_r == SEND);
  assign s_eth_payload_axis_tlast  = last_beat_s;
  assign s_eth_payload_axis_tdata  = (state_r == SEND) ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign s_eth_payload_axis_tuser  = 1'b0;
  assign m_axis_tready             = 1'b0;
  assign valid                     = (state_r == DONE);
  assign s_eth_dest_mac            = dest_r;
  assign s_eth_src_mac             = src_r;
  assign s_eth_type                = type_r;
  assign frame_count               = frame_count_r;

  // Frame sequencing: header handshake, one fetch cycle, payload beats, completion pulse
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = HDR;
        else       state_next_s = IDLE;
      end
      HDR: begin
        if (s_eth_hdr_ready) begin
          if (len_r != {LEN_WIDTH{1'b0}}) state_next_s = FETCH;
          else                            state_next_s = DONE;
        end else begin
          state_next_s = HDR;
        end
      end
      FETCH: state_next_s = SEND;
      SEND: begin
        if (beat_hs_s && last_beat_s) state_next_s = DONE;
        else                          state_next_s = SEND;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Read address runs one beat ahead on a handshake so next cycle's rdata is the next beat
  always_comb begin
    mem_raddr = base_r;
    if (state_r == SEND) begin
      mem_raddr = base_r + ADDR_WIDTH'(idx_r) + ADDR_WIDTH'(beat_hs_s);
    end else if (state_r == FETCH) begin
      mem_raddr = base_r + ADDR_WIDTH'(idx_r);
    end else begin
      mem_raddr = base_r;
    end
  end

  // State, descriptor latch, beat index and completed-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      dest_r        <= 48'h0;
      src_r         <= 48'h0;
      type_r        <= 16'h0;
      base_r        <= {ADDR_WIDTH{1'b0}};
      len_r         <= {LEN_WIDTH{1'b0}};
      idx_r         <= {LEN_WIDTH{1'b0}};
      frame_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (start_acc_s) begin
        dest_r <= dest_mac;
        src_r  <= src_mac;
        type_r <= eth_type;
        base_r <= payload_base;
        len_r  <= payload_len;
        idx_r  <= {LEN_WIDTH{1'b0}};
      end else if (beat_hs_s) begin
        idx_r  <= idx_r + LEN_WIDTH'(1'b1);
      end
      if (state_r == DONE) begin
        frame_count_r <= frame_count_r + CNT_WIDTH'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_write_frame_func.sv
// Scoreboard bench for write_frame_func: a default-width instance for frame scenarios and a
// 4-bit-address instance for read-address wrap.
module tb_write_frame_func;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start, start2, busy;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type, payload_base, payload_len;
  logic        hdr_ready, tready;

  logic        start_ready, hdr_valid, tvalid, tlast, tuser, m_tready, valid;
  logic [15:0] mem_raddr, o_type, frame_count;
  logic [7:0]  mem_rdata, tdata;
  logic [47:0] o_dest, o_src;

  logic        start_ready2, hdr_valid2, tvalid2, tlast2, tuser2, m_tready2, valid2;
  logic [3:0]  mem_raddr2;
  logic [15:0] o_type2, frame_count2;
  logic [7:0]  mem_rdata2, tdata2;
  logic [47:0] o_dest2, o_src2;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    exp_count = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem1(input logic [15:0] a);
    return 8'(a + 16'h0091);
  endfunction

  function automatic logic [7:0] mem2(input logic [3:0] a);
    return {4'hC, a};
  endfunction

  always @(posedge clk) mem_rdata  <= mem1(mem_raddr);
  always @(posedge clk) mem_rdata2 <= mem2(mem_raddr2);

  write_frame_func dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type),
    .payload_base(payload_base), .payload_len(payload_len),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .s_eth_hdr_valid(hdr_valid), .s_eth_hdr_ready(hdr_ready),
    .s_eth_dest_mac(o_dest), .s_eth_src_mac(o_src), .s_eth_type(o_type),
    .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tvalid(tvalid),
    .s_eth_payload_axis_tready(tready), .s_eth_payload_axis_tlast(tlast),
    .s_eth_payload_axis_tuser(tuser), .m_axis_tready(m_tready),
    .busy(busy), .valid(valid), .frame_count(frame_count)
  );

  write_frame_func #(.ADDR_WIDTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .start(start2), .start_ready(start_ready2),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type),
    .payload_base(payload_base[3:0]), .payload_len(payload_len),
    .mem_raddr(mem_raddr2), .mem_rdata(mem_rdata2),
    .s_eth_hdr_valid(hdr_valid2), .s_eth_hdr_ready(hdr_ready),
    .s_eth_dest_mac(o_dest2), .s_eth_src_mac(o_src2), .s_eth_type(o_type2),
    .s_eth_payload_axis_tdata(tdata2), .s_eth_payload_axis_tvalid(tvalid2),
    .s_eth_payload_axis_tready(tready), .s_eth_payload_axis_tlast(tlast2),
    .s_eth_payload_axis_tuser(tuser2), .m_axis_tready(m_tready2),
    .busy(busy), .valid(valid2), .frame_count(frame_count2)
  );

  // Runs one frame on the main instance; starts and ends in an IDLE cycle just after a negedge.
  task automatic drive_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             input logic [15:0] b, input logic [15:0] n,
                             input int tmode, input int hdr_delay, input bit poke);
    int cyc = 0, k = 0, hdr_hs_cyc = -10, last_hs_cyc = -10;
    bit hdr_done = 1'b0, done = 1'b0, poked = 1'b0, prev_stall = 1'b0, first_tv = 1'b1;
    logic [7:0]  prev_data = 8'h0;
    logic        prev_last = 1'b0;
    logic [15:0] exp_ra;
    beat_t       e;
    dest_mac = d; src_mac = s; eth_type = t; payload_base = b; payload_len = n;
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back('{data: mem1(b + 16'(i)), last: (i == int'(n) - 1)});
    start = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && !poked && tvalid) begin
        start = 1'b1; dest_mac = ~d; src_mac = ~s; eth_type = ~t;
        payload_base = b + 16'h0100; payload_len = n + 16'd5; poked = 1'b1;
      end
      hdr_ready = (cyc > hdr_delay);
      tready    = (tmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      tests++;
      if (o_dest !== d || o_src !== s || o_type !== t) begin
        fails++;
        $display("FAIL hdr_fields cyc%0d: got %h/%h/%h expected %h/%h/%h", cyc, o_dest, o_src, o_type, d, s, t);
      end
      tests++;
      if (start_ready !== 1'b0) begin
        fails++; $display("FAIL start_ready_busy cyc%0d: got %b expected 0", cyc, start_ready);
      end
      tests++;
      if (hdr_valid !== !hdr_done) begin
        fails++; $display("FAIL hdr_valid cyc%0d: got %b expected %b", cyc, hdr_valid, !hdr_done);
      end
      if (!hdr_done && hdr_valid && hdr_ready) begin
        hdr_done = 1'b1; hdr_hs_cyc = cyc;
      end
      if (tvalid) begin
        if (first_tv) begin
          tests++;
          if (cyc - hdr_hs_cyc != 2) begin
            fails++; $display("FAIL first_beat_latency: got %0d expected 2", cyc - hdr_hs_cyc);
          end
          first_tv = 1'b0;
        end
        if (prev_stall) begin
          tests++;
          if (tdata !== prev_data || tlast !== prev_last) begin
            fails++; $display("FAIL stall_hold cyc%0d: got %h/%b expected %h/%b", cyc, tdata, tlast, prev_data, prev_last);
          end
        end
        exp_ra = b + 16'(k) + (tready ? 16'd1 : 16'd0);
        tests++;
        if (mem_raddr !== exp_ra) begin
          fails++; $display("FAIL send_raddr cyc%0d: got %h expected %h", cyc, mem_raddr, exp_ra);
        end
        if (tready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL extra_beat cyc%0d: got %h expected no beat", cyc, tdata);
          end else begin
            e = exp_q.pop_front();
            if (tdata !== e.data || tlast !== e.last) begin
              fails++; $display("FAIL beat%0d: got %h/%b expected %h/%b", k, tdata, tlast, e.data, e.last);
            end
          end
          k++; last_hs_cyc = cyc;
        end
        prev_stall = !tready; prev_data = tdata; prev_last = tlast;
      end else begin
        prev_stall = 1'b0;
        tests++;
        if (tdata !== 8'h0 || tlast !== 1'b0 || mem_raddr !== b) begin
          fails++; $display("FAIL idle_payload cyc%0d: got %h/%b/%h expected 00/0/%h", cyc, tdata, tlast, mem_raddr, b);
        end
      end
      if (valid) begin
        tests++;
        if (exp_q.size() != 0 || cyc != ((n == 16'd0) ? hdr_hs_cyc : last_hs_cyc) + 1) begin
          fails++; $display("FAIL done_timing cyc%0d: got %0d beats left expected 0 at cyc %0d", cyc, exp_q.size(), ((n == 16'd0) ? hdr_hs_cyc : last_hs_cyc) + 1);
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL frame_timeout: got no valid expected valid within 200 cycles");
      exp_q.delete();
    end
    exp_count++;
    @(negedge clk);
    #1;
    tests++;
    if (valid !== 1'b0 || start_ready !== 1'b1 || frame_count !== 16'(exp_count)) begin
      fails++; $display("FAIL post_frame: got valid=%b ready=%b count=%0d expected 0/1/%0d", valid, start_ready, frame_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; busy = 1'b0;
    dest_mac = 48'h0; src_mac = 48'h0; eth_type = 16'h0; payload_base = 16'h0; payload_len = 16'h0;
    hdr_ready = 1'b0; tready = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (start_ready !== 1'b1 || hdr_valid !== 1'b0 || tvalid !== 1'b0 || tlast !== 1'b0 || valid !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b%b%b%b%b expected 10000", start_ready, hdr_valid, tvalid, tlast, valid);
    end
    tests++;
    if (tuser !== 1'b0 || m_tready !== 1'b0 || tdata !== 8'h0 || mem_raddr !== 16'h0 || frame_count !== 16'h0) begin
      fails++; $display("FAIL reset_data: got %b/%b/%h/%h/%h expected all zero", tuser, m_tready, tdata, mem_raddr, frame_count);
    end
    tests++;
    if (o_dest !== 48'h0 || o_src !== 48'h0 || o_type !== 16'h0) begin
      fails++; $display("FAIL reset_hdr: got %h/%h/%h expected zero", o_dest, o_src, o_type);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (start_ready !== 1'b1 || start_ready2 !== 1'b1) begin
      fails++; $display("FAIL reset_release: got %b/%b expected 1/1", start_ready, start_ready2);
    end
  endtask

  task automatic test_basic();
    drive_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'h0010, 16'd4, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    drive_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'h0010, 16'd4, 1, 3, 1'b0);
  endtask

  task automatic test_zero_len();
    drive_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88B5, 16'h0040, 16'd0, 0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h86DD, 16'h0010, 16'd4, 0, 0, 1'b1);
    drive_frame(48'h010203040506, 48'hA0A1A2A3A4A5, 16'h0806, 16'h0100, 16'd3, 0, 0, 1'b0);
  endtask

  task automatic test_addr_wrap();
    logic [3:0] exp_addr [5];
    int  cyc = 0, k = 0;
    bit  done = 1'b0;
    beat_t e;
    exp_addr[0] = 4'hE; exp_addr[1] = 4'hF; exp_addr[2] = 4'h0; exp_addr[3] = 4'h1; exp_addr[4] = 4'h2;
    payload_base = 16'h000E; payload_len = 16'd4;
    for (int i = 0; i < 4; i++) exp_q.push_back('{data: mem2(exp_addr[i]), last: (i == 3)});
    start2 = 1'b1;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
      start2 = 1'b0; hdr_ready = 1'b1; tready = 1'b1;
      #1;
      if (!start_ready2 && !hdr_valid2 && !tvalid2 && !valid2) begin
        tests++;
        if (mem_raddr2 !== exp_addr[0]) begin
          fails++; $display("FAIL wrap_fetch_addr: got %h expected %h", mem_raddr2, exp_addr[0]);
        end
      end
      if (tvalid2) begin
        tests++;
        if (k > 3 || exp_q.size() == 0) begin
          fails++; $display("FAIL wrap_extra_beat: got %h expected no beat", tdata2);
        end else begin
          e = exp_q.pop_front();
          if (mem_raddr2 !== exp_addr[k+1] || tdata2 !== e.data || tlast2 !== e.last) begin
            fails++; $display("FAIL wrap_beat%0d: got %h/%h/%b expected %h/%h/%b", k, mem_raddr2, tdata2, tlast2, exp_addr[k+1], e.data, e.last);
          end
        end
        k++;
      end
      if (valid2) done = 1'b1;
    end
    tests++;
    if (!done || k != 4) begin
      fails++; $display("FAIL wrap_frame: got done=%b beats=%0d expected 1/4", done, k);
      exp_q.delete();
    end
    @(negedge clk);
    #1;
    tests++;
    if (frame_count2 !== 16'd1) begin
      fails++; $display("FAIL wrap_count: got %0d expected 1", frame_count2);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, k = 0;
    dest_mac = 48'hDEADBEEF0001; src_mac = 48'hCAFEF00D0002; eth_type = 16'h0800;
    payload_base = 16'h0010; payload_len = 16'd4;
    start = 1'b1;
    while (k < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; hdr_ready = 1'b1; tready = 1'b1;
      #1;
      if (tvalid) begin
        tests++;
        if (tlast !== 1'b0) begin
          fails++; $display("FAIL early_tlast beat%0d: got 1 expected 0", k);
        end
        k++;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (start_ready !== 1'b1 || hdr_valid !== 1'b0 || tvalid !== 1'b0 || tlast !== 1'b0 || valid !== 1'b0) begin
      fails++; $display("FAIL midrst_ctrl: got %b%b%b%b%b expected 10000", start_ready, hdr_valid, tvalid, tlast, valid);
    end
    tests++;
    if (tdata !== 8'h0 || mem_raddr !== 16'h0 || frame_count !== 16'h0 || o_dest !== 48'h0 || o_type !== 16'h0) begin
      fails++; $display("FAIL midrst_data: got %h/%h/%0d/%h/%h expected all zero", tdata, mem_raddr, frame_count, o_dest, o_type);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (tvalid !== 1'b0 || start_ready !== 1'b1 || frame_count !== 16'h0) begin
      fails++; $display("FAIL midrst_release: got %b/%b/%0d expected 0/1/0", tvalid, start_ready, frame_count);
    end
    exp_q.delete();
    exp_count = 0;
    drive_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'h0010, 16'd4, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
